cache_lookup_ctrl: RTL and testbench
====================================

CACHE_LOOKUP_CTRL -- requirements
Module: cache_lookup_ctrl

Interface
REQ-001 SHALL have parameters: WAYS 8, ways per set; LINE_W 256, line width in bits; HALT_W 4, halt-tag width; MAIN_W 20, main-tag width.
REQ-002 SHALL have ports: clk in 1, sole clock, rising edge; reset in 1, asynchronous active-low reset.
REQ-003 SHALL have CPU ports: req_valid in 1; req_ready out 1; req_addr in 32; resp_valid out 1; resp_hit out 1; resp_data out 32.
REQ-004 SHALL have set-side outputs: regWrite out 1; decOut1b out 8, one-hot way select; inp_viv out 1; inputData out 256; in_tag out 32, full address.
REQ-005 SHALL have set-side inputs: halt_tags in 32, way i at [4i+3:4i]; out_viv in 1; outMainTag in 20; outData in 256.
REQ-006 SHALL have memory and control ports: mem_req out 1; mem_addr out 32, line-aligned; mem_ack in 1; mem_rdata in 256; flush in 1; busy out 1; hit_count out 16; miss_count out 16.

Function
REQ-007 SHALL use address fields: main tag [31:12], halt tag [11:8], word select [4:2].
REQ-008 SHALL implement states IDLE, HALT, PROBE, REFILL, WRITE, RESP and FLUSH.
REQ-009 SHALL assert req_ready only in IDLE with flush low, and latch req_addr on req_valid && req_ready, then enter HALT.
REQ-010 SHALL, in HALT, latch cand_mask[i] = (halt_tags[i] == addr[11:8]), then enter PROBE, or REFILL when the mask is zero.
REQ-011 SHALL, in PROBE, drive decOut1b as one-hot of the lowest set bit of cand_mask, with regWrite low.
REQ-012 SHALL, in PROBE, treat out_viv && outMainTag == addr[31:12] as a hit: capture outData and go to RESP with resp_hit 1.
REQ-013 SHALL, in PROBE on no hit, clear that mask bit; an empty mask SHALL go to REFILL.
REQ-014 SHALL, in REFILL, hold mem_req high with mem_addr = {addr[31:5],5'b0} until mem_ack, then capture mem_rdata and enter WRITE.
REQ-015 SHALL, in WRITE, pulse regWrite for one cycle with decOut1b = one-hot(victim), inp_viv 1, inputData = captured line and in_tag = addr.
REQ-016 SHALL, after WRITE, increment the 3-bit round-robin victim counter mod 8 (7 wraps to 0) and enter RESP with resp_hit 0.
REQ-017 SHALL, in RESP, pulse resp_valid one cycle with resp_data = line word addr[4:2], then return to IDLE.
REQ-018 SHALL hold resp_data stable until the next RESP.
REQ-019 SHALL give hit latency of 3 cycles from handshake when the first candidate hits, plus 1 cycle per extra candidate probed.
REQ-020 SHALL, when flush is sampled high in IDLE, enter FLUSH and write inp_viv 0 to ways 0..7 over 8 cycles with regWrite 1, then return to IDLE.
REQ-021 SHALL give flush priority over req_valid when both are high in IDLE.
REQ-022 SHALL ignore flush outside IDLE; flush is not queued.
REQ-023 SHALL increment hit_count and miss_count in RESP, saturating at 16'hFFFF.
REQ-024 SHALL drive busy = (state != IDLE).
REQ-025 SHALL drive decOut1b to 0 in IDLE, HALT, REFILL and RESP.

Reset
REQ-026 SHALL, on reset low, asynchronously force state IDLE, victim 0, cand_mask 0, both counters 0.
REQ-027 SHALL, on reset low, asynchronously force to 0: req_ready, resp_valid, resp_hit, resp_data, regWrite, decOut1b, inp_viv, inputData, in_tag, mem_req, mem_addr and busy.
REQ-028 SHALL, on reset asserted mid-REFILL or mid-FLUSH, drop mem_req and regWrite immediately with no write issued.
REQ-029 SHALL reach IDLE with req_ready 1 on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place in shared package cache_pkg: the state enumeration, the field-position constants and the width parameters.
REQ-031 SHALL use one sub-module, way_halt_match, for halt compare plus lowest-set-bit one-hot priority select.

Verification
REQ-032 SHALL test cold miss: reset, then request 0x0000_1A40 -> mem_req with mem_addr 0x0000_1A40; ack; WRITE decOut1b 8'h01; RESP resp_hit 0; miss_count 1.
REQ-033 SHALL test hit: preload way 3 valid with tag 0x00001 and halt 0xA; read 0x0000_1A48 -> one probe, resp_valid 3 cycles after handshake, resp_hit 1, resp_data = line word 2.
REQ-034 SHALL test halt alias: ways 1 and 5 halt 0xA, only way 5 main tag matches -> probes 8'h02 then 8'h20; hit latency 4.
REQ-035 SHALL test victim wrap: 9 consecutive misses -> WRITE decOut1b 01,02,...,80,01.
REQ-036 SHALL test flush and reset: flush and req_valid high together in IDLE -> 8 invalidate writes first; reset low mid-REFILL -> mem_req 0 same cycle, counters 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the cache lookup controller.
package cache_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned CACHE_WAYS   = 8;
  localparam int unsigned CACHE_LINE_W = 256;
  localparam int unsigned CACHE_HALT_W = 4;
  localparam int unsigned CACHE_MAIN_W = 20;

  localparam int unsigned MAIN_LSB   = 12;
  localparam int unsigned HALT_LSB   = 8;
  localparam int unsigned WORD_LSB   = 2;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned LINE_OFF_W = 5;

  typedef enum logic [2:0] {
    IDLE, HALT, PROBE, REFILL, WRITE, RESP, FLUSH
  } ctrlState_e;

endpackage

// File: rtl/cache_lookup_ctrl_if.sv
// CPU-side request/response channel of the cache lookup controller.
interface cache_lookup_ctrl_if;

  logic                         req_valid;
  logic                         req_ready;
  logic [cache_pkg::ADDR_W-1:0] req_addr;
  logic                         resp_valid;
  logic                         resp_hit;
  logic [cache_pkg::WORD_W-1:0] resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_hit, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_hit, resp_data
  );

endinterface

// File: rtl/way_halt_match.sv
// Halt-tag compare across all ways plus lowest-set-bit one-hot select of the candidate mask.
module way_halt_match
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = CACHE_WAYS,
  parameter int unsigned HALT_W = CACHE_HALT_W
) (
  input  logic [WAYS*HALT_W-1:0] haltTags,
  input  logic [HALT_W-1:0]      haltTag,
  input  logic [WAYS-1:0]        remMask,
  input  logic                   useMatch,
  output logic [WAYS-1:0]        candMask,
  output logic [WAYS-1:0]        selOneHot
);

  logic [WAYS-1:0] matchMask;

  always_comb begin
    matchMask = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      matchMask[i] = (haltTags[i*HALT_W +: HALT_W] == haltTag);
    end
  end

  assign candMask = useMatch ? matchMask : remMask;

  // x & -x keeps only the lowest set bit
  assign selOneHot = candMask & (~candMask + WAYS'(1));

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Set-associative lookup controller: halt-tag filter, sequential way probe,
// line refill with round-robin victim, and whole-set flush.
module cache_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS   = CACHE_WAYS,
  parameter int unsigned LINE_W = CACHE_LINE_W,
  parameter int unsigned HALT_W = CACHE_HALT_W,
  parameter int unsigned MAIN_W = CACHE_MAIN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_lookup_ctrl_if.slave     cpu,
  output logic                   regWrite,
  output logic [WAYS-1:0]        decOut1b,
  output logic                   inp_viv,
  output logic [LINE_W-1:0]      inputData,
  output logic [ADDR_W-1:0]      in_tag,
  input  logic [WAYS*HALT_W-1:0] halt_tags,
  input  logic                   out_viv,
  input  logic [MAIN_W-1:0]      outMainTag,
  input  logic [LINE_W-1:0]      outData,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   flush,
  output logic                   busy,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);

  localparam int unsigned VICT_W = $clog2(WAYS);

  ctrlState_e          state, stateD;
  logic [ADDR_W-1:0]   addrQ, addrD;
  logic [WAYS-1:0]     candQ, candD;
  logic [VICT_W-1:0]   victim, victimD, flushIdx, flushIdxD;
  logic [LINE_W-1:0]   lineBuf, lineD;
  logic                readyQ, readyD;
  logic                respValidQ, respValidD, respHitQ, respHitD;
  logic [WORD_W-1:0]   respDataQ, respDataD;
  logic                regWriteD, vivD, memReqD, busyD;
  logic [WAYS-1:0]     decD;
  logic [LINE_W-1:0]   inputDataD;
  logic [ADDR_W-1:0]   inTagD, memAddrD;
  logic [CNT_W-1:0]    hitD, missD;
  logic [WAYS-1:0]     candNext, selNext;
  logic [WORD_SEL_W-1:0] wordSel;
  logic                reqReady, probeHit;

  // Ready is registered for IDLE but gated live by flush so flush always wins
  assign reqReady       = readyQ && !flush;
  assign cpu.req_ready  = reqReady;
  assign cpu.resp_valid = respValidQ;
  assign cpu.resp_hit   = respHitQ;
  assign cpu.resp_data  = respDataQ;

  assign wordSel  = addrQ[WORD_LSB +: WORD_SEL_W];
  assign probeHit = out_viv && (outMainTag == addrQ[MAIN_LSB +: MAIN_W]);

  way_halt_match #(.WAYS(WAYS), .HALT_W(HALT_W)) u_match (
    .haltTags  (halt_tags),
    .haltTag   (addrQ[HALT_LSB +: HALT_W]),
    .remMask   (candQ & ~decOut1b),
    .useMatch  (state == HALT),
    .candMask  (candNext),
    .selOneHot (selNext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addrQ      <= '0;
      candQ      <= '0;
      victim     <= '0;
      flushIdx   <= '0;
      lineBuf    <= '0;
      readyQ     <= 1'b0;
      respValidQ <= 1'b0;
      respHitQ   <= 1'b0;
      respDataQ  <= '0;
      regWrite   <= 1'b0;
      decOut1b   <= '0;
      inp_viv    <= 1'b0;
      inputData  <= '0;
      in_tag     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= stateD;
      addrQ      <= addrD;
      candQ      <= candD;
      victim     <= victimD;
      flushIdx   <= flushIdxD;
      lineBuf    <= lineD;
      readyQ     <= readyD;
      respValidQ <= respValidD;
      respHitQ   <= respHitD;
      respDataQ  <= respDataD;
      regWrite   <= regWriteD;
      decOut1b   <= decD;
      inp_viv    <= vivD;
      inputData  <= inputDataD;
      in_tag     <= inTagD;
      mem_req    <= memReqD;
      mem_addr   <= memAddrD;
      busy       <= busyD;
      hit_count  <= hitD;
      miss_count <= missD;
    end
  end

  // Next state plus next values of every registered output, aligned to the next state
  always_comb begin
    stateD     = state;
    addrD      = addrQ;
    candD      = candQ;
    victimD    = victim;
    flushIdxD  = flushIdx;
    lineD      = lineBuf;
    respValidD = 1'b0;
    respHitD   = respHitQ;
    respDataD  = respDataQ;
    regWriteD  = 1'b0;
    decD       = '0;
    vivD       = 1'b0;
    inputDataD = inputData;
    inTagD     = in_tag;
    memReqD    = 1'b0;
    memAddrD   = mem_addr;
    hitD       = hit_count;
    missD      = miss_count;

    unique case (state)
      IDLE: begin
        if (flush) begin
          stateD    = FLUSH;
          flushIdxD = '0;
          regWriteD = 1'b1;
          decD      = WAYS'(1);
        end else if (cpu.req_valid && reqReady) begin
          addrD  = cpu.req_addr;
          stateD = HALT;
        end
      end
      HALT, PROBE: begin
        if (state == PROBE && probeHit) begin
          stateD     = RESP;
          lineD      = outData;
          respValidD = 1'b1;
          respHitD   = 1'b1;
          respDataD  = outData[WORD_W*32'(wordSel) +: WORD_W];
        end else begin
          candD = candNext;
          if (candNext == '0) begin
            stateD   = REFILL;
            memReqD  = 1'b1;
            memAddrD = {addrQ[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          end else begin
            stateD = PROBE;
            decD   = selNext;
          end
        end
      end
      REFILL: begin
        if (mem_ack) begin
          stateD     = WRITE;
          lineD      = mem_rdata;
          regWriteD  = 1'b1;
          decD       = WAYS'(1) << victim;
          vivD       = 1'b1;
          inputDataD = mem_rdata;
          inTagD     = addrQ;
        end else begin
          memReqD = 1'b1;
        end
      end
      WRITE: begin
        stateD     = RESP;
        victimD    = victim + VICT_W'(1);
        respValidD = 1'b1;
        respHitD   = 1'b0;
        respDataD  = lineBuf[WORD_W*32'(wordSel) +: WORD_W];
      end
      RESP: begin
        stateD = IDLE;
        if (respHitQ) begin
          if (hit_count != '1) hitD = hit_count + CNT_W'(1);
        end else begin
          if (miss_count != '1) missD = miss_count + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (flushIdx == VICT_W'(WAYS - 1)) begin
          stateD = IDLE;
        end else begin
          flushIdxD = flushIdx + VICT_W'(1);
          regWriteD = 1'b1;
          decD      = WAYS'(1) << flushIdxD;
        end
      end
      default: stateD = IDLE;
    endcase

    readyD = (stateD == IDLE);
    busyD  = (stateD != IDLE);
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed bench for cache_lookup_ctrl with a behavioural 8-way set and memory responder.
module tb_cache_lookup_ctrl;
  import cache_pkg::*;

  logic         clk;
  logic         reset;
  logic         regWrite;
  logic [7:0]   decOut1b;
  logic         inp_viv;
  logic [255:0] inputData;
  logic [31:0]  in_tag;
  logic [31:0]  halt_tags;
  logic         out_viv;
  logic [19:0]  outMainTag;
  logic [255:0] outData;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [255:0] mem_rdata;
  logic         flush;
  logic         busy;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int nChecks = 0;
  int nFails  = 0;

  cache_lookup_ctrl_if cpu ();

  cache_lookup_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu),
    .regWrite   (regWrite),
    .decOut1b   (decOut1b),
    .inp_viv    (inp_viv),
    .inputData  (inputData),
    .in_tag     (in_tag),
    .halt_tags  (halt_tags),
    .out_viv    (out_viv),
    .outMainTag (outMainTag),
    .outData    (outData),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .busy       (busy),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural set array, preload port and write/probe logs
  logic         wayValid [8];
  logic [19:0]  wayMain  [8];
  logic [3:0]   wayHalt  [8];
  logic [255:0] wayData  [8];
  logic         plEn;
  int           plWay;
  logic         plValid;
  logic [31:0]  plAddr;
  logic [255:0] plData;
  logic [7:0]   wrDecLog [$];
  logic         wrVivLog [$];
  logic [7:0]   probeLog [$];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        wayValid[i] <= 1'b0;
        wayMain[i]  <= '0;
        wayHalt[i]  <= '0;
        wayData[i]  <= '0;
      end
    end else if (regWrite) begin
      for (int i = 0; i < 8; i++) begin
        if (decOut1b[i]) begin
          wayValid[i] <= inp_viv;
          wayMain[i]  <= in_tag[31:12];
          wayHalt[i]  <= in_tag[11:8];
          wayData[i]  <= inputData;
        end
      end
      wrDecLog.push_back(decOut1b);
      wrVivLog.push_back(inp_viv);
    end else begin
      if (busy && decOut1b != 8'h00) probeLog.push_back(decOut1b);
      if (plEn) begin
        wayValid[plWay] <= plValid;
        wayMain[plWay]  <= plAddr[31:12];
        wayHalt[plWay]  <= plAddr[11:8];
        wayData[plWay]  <= plData;
      end
    end
  end

  always_comb begin
    halt_tags = '0;
    for (int i = 0; i < 8; i++) halt_tags[i*4 +: 4] = wayHalt[i];
  end

  always_comb begin
    out_viv    = 1'b0;
    outMainTag = '0;
    outData    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (decOut1b[i]) begin
        out_viv    = wayValid[i];
        outMainTag = wayMain[i];
        outData    = wayData[i];
      end
    end
  end

  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic preload(input int way, input logic v, input logic [31:0] addr, input logic [255:0] line);
    @(negedge clk);
    plEn = 1'b1; plWay = way; plValid = v; plAddr = addr; plData = line;
    @(negedge clk);
    plEn = 1'b0;
  endtask

  task automatic clear_set();
    for (int i = 0; i < 8; i++) preload(i, 1'b0, 32'h0, '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  // Issue one read, serve any refill after ackDelay cycles, capture the response
  task automatic run_read(input logic [31:0] addr, input int ackDelay,
                          output int lat, output logic hit, output logic [31:0] data,
                          output logic memSeen, output logic [31:0] memAddrSeen);
    int n;
    int waitCnt;
    lat = 0; hit = 1'bx; data = 'x; memSeen = 1'b0; memAddrSeen = '0; waitCnt = 0;
    @(negedge clk);
    cpu.req_valid = 1'b1;
    cpu.req_addr  = addr;
    n = 0;
    while (!cpu.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cpu.req_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!memSeen) begin
          memSeen = 1'b1;
          memAddrSeen = mem_addr;
        end
        waitCnt++;
        if (waitCnt >= ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = makeLine(mem_addr);
        end
      end
      if (cpu.resp_valid) begin
        lat = i; hit = cpu.resp_hit; data = cpu.resp_data;
        break;
      end
    end
    if (lat == 0) $display("FAIL %s: response timeout for addr %h", "read_timeout", addr);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++;
    if (cpu.req_ready !== 1'b0 || cpu.resp_valid !== 1'b0 || regWrite !== 1'b0 || mem_req !== 1'b0) begin
      nFails++;
      $display("FAIL reset_ctrl: got ready=%b rv=%b rw=%b mreq=%b expected all 0", cpu.req_ready, cpu.resp_valid, regWrite, mem_req);
    end
    nChecks++;
    if (decOut1b !== 8'h00 || busy !== 1'b0 || mem_addr !== 32'h0 || in_tag !== 32'h0 || cpu.resp_data !== 32'h0) begin
      nFails++;
      $display("FAIL reset_data: got dec=%h busy=%b maddr=%h tag=%h rdata=%h expected 0", decOut1b, busy, mem_addr, in_tag, cpu.resp_data);
    end
    nChecks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      nFails++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", hit_count, miss_count);
    end
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if (cpu.req_ready !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL reset_release_ready: got ready=%b busy=%b expected 1/0", cpu.req_ready, busy);
    end
  endtask

  task automatic test_cold_miss();
    int lat; logic hit; logic [31:0] data; logic ms; logic [31:0] ma; int base;
    base = wrDecLog.size();
    run_read(32'h0000_1A40, 2, lat, hit, data, ms, ma);
    nChecks++;
    if (ms !== 1'b1 || ma !== 32'h0000_1A40) begin
      nFails++;
      $display("FAIL miss_mem_addr: got seen=%b addr=%h expected 1 00001a40", ms, ma);
    end
    nChecks++;
    if (wrDecLog.size() != base + 1 || wrDecLog[base] !== 8'h01 || wrVivLog[base] !== 1'b1) begin
      nFails++;
      $display("FAIL miss_write_way: got %0d writes expected one write to 01 valid", wrDecLog.size() - base);
    end
    nChecks++;
    if (hit !== 1'b0 || data !== 32'h0000_1A40) begin
      nFails++;
      $display("FAIL miss_resp: got hit=%b data=%h expected 0 00001a40", hit, data);
    end
    @(negedge clk);
    nChecks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      nFails++;
      $display("FAIL miss_count: got miss=%0d hit=%0d expected 1/0", miss_count, hit_count);
    end
  endtask

  task automatic test_hit();
    int lat; logic hit; logic [31:0] data; logic ms; logic [31:0] ma; int pbase;
    clear_set();
    preload(3, 1'b1, 32'h0000_1A00, makeLine(32'hC0DE_0300));
    pbase = probeLog.size();
    run_read(32'h0000_1A48, 2, lat, hit, data, ms, ma);
    nChecks++;
    if (lat !== 3) begin
      nFails++;
      $display("FAIL hit_latency: got %0d expected 3", lat);
    end
    nChecks++;
    if (hit !== 1'b1 || data !== 32'hC0DE_0302) begin
      nFails++;
      $display("FAIL hit_resp: got hit=%b data=%h expected 1 c0de0302", hit, data);
    end
    nChecks++;
    if (probeLog.size() != pbase + 1 || probeLog[pbase] !== 8'h08 || ms !== 1'b0) begin
      nFails++;
      $display("FAIL hit_probe: got %0d probes memreq=%b expected one probe of 08, no refill", probeLog.size() - pbase, ms);
    end
    @(negedge clk);
    nChecks++;
    if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      nFails++;
      $display("FAIL hit_count: got hit=%0d miss=%0d expected 1/1", hit_count, miss_count);
    end
  endtask

  task automatic test_halt_alias();
    int lat; logic hit; logic [31:0] data; logic ms; logic [31:0] ma; int pbase;
    clear_set();
    preload(1, 1'b1, 32'h0000_2A00, makeLine(32'h1111_0000));
    preload(5, 1'b1, 32'h0000_1A00, makeLine(32'h5555_0000));
    pbase = probeLog.size();
    run_read(32'h0000_1A44, 2, lat, hit, data, ms, ma);
    nChecks++;
    if (lat !== 4) begin
      nFails++;
      $display("FAIL alias_latency: got %0d expected 4", lat);
    end
    nChecks++;
    if (hit !== 1'b1 || data !== 32'h5555_0001) begin
      nFails++;
      $display("FAIL alias_resp: got hit=%b data=%h expected 1 55550001", hit, data);
    end
    nChecks++;
    if (probeLog.size() != pbase + 2 || probeLog[pbase] !== 8'h02 || probeLog[pbase+1] !== 8'h20) begin
      nFails++;
      $display("FAIL alias_probes: got %0d probes expected 02 then 20", probeLog.size() - pbase);
    end
    @(negedge clk);
    nChecks++;
    if (hit_count !== 16'd2) begin
      nFails++;
      $display("FAIL alias_hit_count: got %0d expected 2", hit_count);
    end
  endtask

  task automatic test_victim_wrap();
    int lat; logic hit; logic [31:0] data; logic ms; logic [31:0] ma; int base;
    logic [7:0] expDec;
    pulse_reset();
    base = wrDecLog.size();
    for (int i = 0; i < 9; i++) begin
      run_read(32'h0010_0B00 + (32'(i) << 12), 1, lat, hit, data, ms, ma);
      nChecks++;
      expDec = 8'h01 << (i % 8);
      if (wrDecLog.size() != base + i + 1 || wrDecLog[base+i] !== expDec || hit !== 1'b0) begin
        nFails++;
        $display("FAIL victim_wrap_%0d: got %0d writes hit=%b expected write to %h, miss", i, wrDecLog.size() - base, hit, expDec);
      end
    end
    @(negedge clk);
    nChecks++;
    if (miss_count !== 16'd9 || hit_count !== 16'd0) begin
      nFails++;
      $display("FAIL wrap_counts: got miss=%0d hit=%0d expected 9/0", miss_count, hit_count);
    end
  endtask

  task automatic test_flush();
    int lat; logic hit; logic [31:0] data; logic ms; logic [31:0] ma; int base; logic ok;
    base = wrDecLog.size();
    @(negedge clk);
    flush = 1'b1;
    cpu.req_valid = 1'b1;
    cpu.req_addr  = 32'h0000_2B40;
    #1;
    nChecks++;
    if (cpu.req_ready !== 1'b0) begin
      nFails++;
      $display("FAIL flush_blocks_ready: got %b expected 0", cpu.req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    nChecks++;
    if (busy !== 1'b1 || regWrite !== 1'b1 || decOut1b !== 8'h01 || inp_viv !== 1'b0) begin
      nFails++;
      $display("FAIL flush_start: got busy=%b rw=%b dec=%h viv=%b expected 1 1 01 0", busy, regWrite, decOut1b, inp_viv);
    end
    run_read(32'h0000_2B40, 1, lat, hit, data, ms, ma);
    ok = (wrDecLog.size() == base + 9);
    for (int i = 0; i < 8 && ok; i++) begin
      if (wrDecLog[base+i] !== (8'h01 << i) || wrVivLog[base+i] !== 1'b0) ok = 1'b0;
    end
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("FAIL flush_writes: got %0d writes expected 8 invalidates 01..80 then the refill", wrDecLog.size() - base);
    end
    nChecks++;
    if (ok && (wrVivLog[base+8] !== 1'b1 || hit !== 1'b0 || ma !== 32'h0000_2B40)) begin
      nFails++;
      $display("FAIL flush_then_req: got viv=%b hit=%b maddr=%h expected 1 0 00002b40", wrVivLog[base+8], hit, ma);
    end
  endtask

  task automatic test_reset_refill();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    cpu.req_valid = 1'b1;
    cpu.req_addr  = 32'h0030_0C00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cpu.req_valid = 1'b0;
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("FAIL rst_refill_reach: got no mem_req expected refill");
    end
    reset = 1'b0;
    #1;
    nChecks++;
    if (mem_req !== 1'b0 || regWrite !== 1'b0 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL rst_refill_drop: got mreq=%b rw=%b busy=%b expected 0 0 0", mem_req, regWrite, busy);
    end
    nChecks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      nFails++;
      $display("FAIL rst_refill_counters: got %h/%h expected 0/0", hit_count, miss_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if (cpu.req_ready !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL rst_refill_recover: got ready=%b busy=%b expected 1 0", cpu.req_ready, busy);
    end
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    plEn = 1'b0; plWay = 0; plValid = 1'b0; plAddr = '0; plData = '0;
    cpu.req_valid = 1'b0;
    cpu.req_addr  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit();
    test_halt_alias();
    test_victim_wrap();
    test_flush();
    test_reset_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
